// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM radio front end.
//   DATA_WIDTH_DEF / QUANT_BITS_DEF : default sample width and quantization shift
//   unpack_state_t                  : byte position within a little-endian I/Q pair
//   quantize16(hi, lo)              : sign-extend a 16-bit component and scale by 2^QUANT_BITS_DEF
package fm_radio_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int QUANT_BITS_DEF = 10;

  typedef enum logic [1:0] {
    BYTE0 = 2'd0,
    BYTE1 = 2'd1,
    BYTE2 = 2'd2,
    BYTE3 = 2'd3
  } unpack_state_t;

  function automatic logic [DATA_WIDTH_DEF-1:0] quantize16(input logic [7:0] hi,
                                                           input logic [7:0] lo);
    logic [DATA_WIDTH_DEF-1:0] ext;
    ext = {{(DATA_WIDTH_DEF-16){hi[7]}}, hi, lo};
    return ext << QUANT_BITS_DEF;
  endfunction

endpackage

// File: rtl/iq_byte_unpack.sv
// Byte-to-I/Q unpacker feeding the I and Q channel FIRs.
// Pops bytes from a show-ahead byte FIFO, assembles little-endian 16-bit I/Q pairs
// (I_lo, I_hi, Q_lo, Q_hi), sign-extends and scales each component by 2^QUANT_BITS,
// and presents them on two independent valid/rd_en output channels.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_dout, in_empty   byte FIFO head and empty flag
//   in_rd_en            pop the byte FIFO this cycle (never while in_empty)
//   i_data, i_valid     quantized I sample and its valid flag
//   i_rd_en             I consumer takes i_data this cycle
//   q_data, q_valid     quantized Q sample and its valid flag
//   q_rd_en             Q consumer takes q_data this cycle
//   sample_cnt          number of I/Q pairs loaded since reset (wraps)
//
// State  | meaning
// BYTE0  | waiting for I low byte
// BYTE1  | waiting for I high byte
// BYTE2  | waiting for Q low byte
// BYTE3  | waiting for Q high byte and for both output channels to be free
module iq_byte_unpack
  import fm_radio_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int QUANT_BITS = QUANT_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_valid,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] q_data,
  output logic                  q_valid,
  input  logic                  q_rd_en,
  output logic [31:0]           sample_cnt
);

  if (DATA_WIDTH < 16 + QUANT_BITS) begin : g_width_check
    $error("iq_byte_unpack: DATA_WIDTH must be at least 16 + QUANT_BITS");
  end

  function automatic logic [DATA_WIDTH-1:0] quantize(input logic [7:0] hi,
                                                     input logic [7:0] lo);
    logic [DATA_WIDTH-1:0] ext;
    ext = {{(DATA_WIDTH-16){hi[7]}}, hi, lo};
    return ext << QUANT_BITS;
  endfunction

  unpack_state_t         state_q, state_d;
  logic [7:0]            b0_q, b0_d;
  logic [7:0]            b1_q, b1_d;
  logic [7:0]            b2_q, b2_d;
  logic [DATA_WIDTH-1:0] i_data_q, i_data_d;
  logic [DATA_WIDTH-1:0] q_data_q, q_data_d;
  logic                  i_valid_q, i_valid_d;
  logic                  q_valid_q, q_valid_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  load_ok;
  logic                  load;

  always_comb begin
    state_d   = state_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    in_rd_en  = 1'b0;
    load      = 1'b0;
    // Both channels must be empty or emptying this cycle before a new pair may land.
    load_ok   = (!i_valid_q || i_rd_en) && (!q_valid_q || q_rd_en);

    // Gating with reset keeps the FIFO untouched while the block is being cleared.
    if (!reset && !in_empty) begin
      case (state_q)
        BYTE0: begin
          in_rd_en = 1'b1;
          b0_d     = in_dout;
          state_d  = BYTE1;
        end
        BYTE1: begin
          in_rd_en = 1'b1;
          b1_d     = in_dout;
          state_d  = BYTE2;
        end
        BYTE2: begin
          in_rd_en = 1'b1;
          b2_d     = in_dout;
          state_d  = BYTE3;
        end
        BYTE3: begin
          if (load_ok) begin
            in_rd_en = 1'b1;
            load     = 1'b1;
            state_d  = BYTE0;
          end
        end
        default: state_d = BYTE0;
      endcase
    end

    i_valid_d = i_valid_q && !i_rd_en;
    q_valid_d = q_valid_q && !q_rd_en;
    i_data_d  = i_data_q;
    q_data_d  = q_data_q;
    cnt_d     = cnt_q;

    // The Q high byte is taken straight from the FIFO head, never staged.
    if (load) begin
      i_data_d  = quantize(b1_q, b0_q);
      q_data_d  = quantize(in_dout, b2_q);
      i_valid_d = 1'b1;
      q_valid_d = 1'b1;
      cnt_d     = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= BYTE0;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
      b2_q      <= 8'h00;
      i_data_q  <= '0;
      q_data_q  <= '0;
      i_valid_q <= 1'b0;
      q_valid_q <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      i_data_q  <= i_data_d;
      q_data_q  <= q_data_d;
      i_valid_q <= i_valid_d;
      q_valid_q <= q_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign i_data     = i_data_q;
  assign q_data     = q_data_q;
  assign i_valid    = i_valid_q;
  assign q_valid    = q_valid_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_iq_byte_unpack.sv
// Testbench for iq_byte_unpack: byte FIFO driver, scoreboard monitor, directed and random tests.
module tb_iq_byte_unpack;

  localparam int DW = 32;
  localparam int QB = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_dout = 8'h00;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          i_rd_en = 1'b0;
  logic [DW-1:0] q_data;
  logic          q_valid;
  logic          q_rd_en = 1'b0;
  logic [31:0]   sample_cnt;

  always #5 clock = ~clock;

  iq_byte_unpack #(.DATA_WIDTH(DW), .QUANT_BITS(QB)) dut (
    .clock(clock), .reset(reset),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .i_data(i_data), .i_valid(i_valid), .i_rd_en(i_rd_en),
    .q_data(q_data), .q_valid(q_valid), .q_rd_en(q_rd_en),
    .sample_cnt(sample_cnt)
  );

  int total = 0;
  int bad = 0;

  logic [7:0]  src_q[$];   // bytes waiting in the modelled FIFO
  logic [7:0]  grp[$];     // bytes of the pair currently being issued
  logic [31:0] exp_i[$];
  logic [31:0] exp_q[$];
  int          pairs_since_reset = 0;
  int          i_mode = 1;  // 0 = rd_en low, 1 = high, 2 = random
  int          q_mode = 1;
  int          gap_pct = 0;
  logic [31:0] last_i = '0;
  logic [31:0] last_q = '0;

  // Reference: signed 16-bit value times 2^QB, as a 32-bit two's-complement word.
  function automatic logic [31:0] model(input logic [7:0] hi, input logic [7:0] lo);
    longint v;
    v = longint'({hi, lo});
    if (v >= 32768) v = v - 65536;
    return 32'(v * (2 ** QB));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    src_q.push_back(b);
    grp.push_back(b);
    if (grp.size() == 4) begin
      exp_i.push_back(model(grp[1], grp[0]));
      exp_q.push_back(model(grp[3], grp[2]));
      grp.delete();
      pairs_since_reset++;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    src_q.delete();
    grp.delete();
    exp_i.delete();
    exp_q.delete();
    pairs_since_reset = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_i.size() != 0 || exp_q.size() != 0) && n < 6000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 6000) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=src%0d/i%0d/q%0d required=0/0/0",
               name, src_q.size(), exp_i.size(), exp_q.size());
    end
    @(negedge clock);
    #3;
    check({name, "_cnt"}, sample_cnt, 32'(pairs_since_reset));
  endtask

  // FIFO and consumer driver: inputs change on the falling edge only.
  initial begin : driver
    bit pop;
    forever begin
      @(negedge clock);
      if (src_q.size() == 0 || int'($urandom_range(99)) < gap_pct) begin
        in_empty = 1'b1;
        in_dout  = 8'($urandom);
      end else begin
        in_empty = 1'b0;
        in_dout  = src_q[0];
      end
      i_rd_en = (i_mode == 2) ? 1'($urandom_range(1)) : (i_mode == 1);
      q_rd_en = (q_mode == 2) ? 1'($urandom_range(1)) : (q_mode == 1);
      #1;
      pop = in_rd_en;
      if (in_empty) check("rd_en_while_empty", {31'd0, in_rd_en}, 32'd0);
      @(posedge clock);
      if (pop && src_q.size() != 0) void'(src_q.pop_front());
    end
  end

  // Scoreboard monitor: compares on every transfer.
  initial begin : monitor
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        if (i_valid && i_rd_en) begin
          if (exp_i.size() == 0) begin
            total++; bad++;
            $display("FAIL i_unexpected actual=%h required=no_sample", i_data);
          end else check("i_data", i_data, exp_i.pop_front());
          last_i = i_data;
        end
        if (q_valid && q_rd_en) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL q_unexpected actual=%h required=no_sample", q_data);
          end else check("q_data", q_data, exp_q.pop_front());
          last_q = q_data;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    logic [16:0] pop_mask, iv_mask, qv_mask;

    // Reset state, with a byte on offer that must not be popped.
    repeat (3) @(negedge clock);
    src_q.push_back(8'hAA);
    @(negedge clock);
    #3;
    check("rst_i_valid", {31'd0, i_valid}, 32'd0);
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_i_data", i_data, 32'd0);
    check("rst_q_data", q_data, 32'd0);
    check("rst_cnt", sample_cnt, 32'd0);
    check("rst_in_rd_en", {31'd0, in_rd_en}, 32'd0);
    src_q.delete();
    @(negedge clock);
    reset = 1'b0;

    // 1: one pair, consumers always ready -> single valid pulse.
    @(posedge clock); #1;
    push_byte(8'h01); push_byte(8'h00); push_byte(8'hFF); push_byte(8'hFF);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock); #3;
      if (i_valid) n++;
    end
    check("t1_pulses", 32'(n), 32'd1);
    drain("t1");
    check("t1_i", last_i, 32'h0000_0400);
    check("t1_q", last_q, 32'hFFFF_FC00);

    // 2: extreme values.
    do_reset();
    @(posedge clock); #1;
    push_byte(8'h00); push_byte(8'h80); push_byte(8'hFF); push_byte(8'h7F);
    drain("t2");
    check("t2_i", last_i, 32'hFE00_0000);
    check("t2_q", last_q, 32'h01FF_FC00);

    // 3: eight bytes back to back; pops at samples 1..8, valids at samples 5 and 9.
    @(posedge clock); #1;
    for (int k = 0; k < 8; k++) push_byte(8'($urandom));
    pop_mask = '0; iv_mask = '0; qv_mask = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock); #3;
      pop_mask[k] = in_rd_en;
      iv_mask[k]  = i_valid;
      qv_mask[k]  = q_valid;
    end
    check("t3_pops", 32'(pop_mask), 32'h0000_01FE);
    check("t3_i_valid", 32'(iv_mask), 32'h0000_0220);
    check("t3_q_valid", 32'(qv_mask), 32'h0000_0220);
    drain("t3");

    // 4: FIFO runs dry after the I bytes.
    @(posedge clock); #1;
    push_byte(8'h34); push_byte(8'h92);
    repeat (4) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #3;
      check("t4_hold_rd_en", {31'd0, in_rd_en}, 32'd0);
      check("t4_hold_valid", {31'd0, i_valid}, 32'd0);
    end
    check("t4_hold_cnt", sample_cnt, 32'd3);
    @(posedge clock); #1;
    push_byte(8'hC5); push_byte(8'h0E);
    drain("t4");

    // 5: Q consumer stalls; next pair waits in BYTE3 with its last byte unpopped.
    q_mode = 0;
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++) push_byte(8'($urandom));
    repeat (8) @(negedge clock);
    #3;
    check("t5_q_valid", {31'd0, q_valid}, 32'd1);
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++) push_byte(8'($urandom));
    repeat (10) @(negedge clock);
    #3;
    check("t5_left", 32'(src_q.size()), 32'd1);
    check("t5_stall_rd_en", {31'd0, in_rd_en}, 32'd0);
    q_mode = 1;
    drain("t5");

    // 6: reset mid-pair discards the partial bytes.
    do_reset();
    @(posedge clock); #1;
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    n = 0;
    while (src_q.size() != 0 && n < 50) begin @(negedge clock); n++; end
    check("t6_partial_popped", 32'(src_q.size()), 32'd0);
    do_reset();
    @(posedge clock); #1;
    push_byte(8'h04); push_byte(8'h00); push_byte(8'h08); push_byte(8'h00);
    drain("t6");
    check("t6_i", last_i, 32'h0000_1000);
    check("t6_q", last_q, 32'h0000_2000);

    // Random traffic: FIFO gaps and independent random consumers.
    i_mode = 2; q_mode = 2; gap_pct = 30;
    @(posedge clock); #1;
    for (int k = 0; k < 400; k++) push_byte(8'($urandom));
    drain("rand");
    i_mode = 1; q_mode = 1; gap_pct = 0;
    @(posedge clock); #1;
    for (int k = 0; k < 40; k++) push_byte(8'($urandom));
    drain("rand_fast");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
